// File: rtl/pads_out_pkg.sv
// Shared definitions for the output-pad controller: channel modes,
// register addresses and the CH_CTRL field layout.
package pads_out_pkg;

    // Per-channel output source; MODE_RSVD is stored but acts as pass-through.
    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_FORCE = 2'd1,
        MODE_PWM   = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam int unsigned ADDR_W        = 5;
    localparam int unsigned DATA_W        = 32;

    localparam int unsigned ADDR_PRESCALE = 0;
    localparam int unsigned CH_BASE       = 1;

    // CH_CTRL layout
    localparam int unsigned MODE_LSB      = 0;
    localparam int unsigned MODE_W        = 2;
    localparam int unsigned FORCE_BIT     = 2;
    localparam int unsigned DUTY_LSB      = 8;

endpackage

// File: rtl/pads_pwm_timebase.sv
// Shared PWM timebase: a prescaler counting 0..i_prescale that advances
// the PWM counter once per wrap. i_clr restarts both counters.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   i_clr        - clear prescaler and PWM counter on this edge
//   i_prescale   - prescaler terminal count
//   o_pwm_cnt    - free-running PWM counter (wraps at 2^PWM_W)
module pads_pwm_timebase
    import pads_out_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned PWM_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic [PWM_W-1:0]      o_pwm_cnt
);

    logic [PRESCALE_W-1:0] r_pre;
    logic                  w_tick;

    // i_prescale only changes together with i_clr, so r_pre never passes it.
    assign w_tick = (r_pre == i_prescale);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_pre     <= '0;
            o_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pre     <= '0;
            o_pwm_cnt <= o_pwm_cnt + PWM_W'(1);
        end else begin
            r_pre     <= r_pre + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/pads_out_ctrl.sv
// Registered output-pad controller. Each channel drives its pad from the
// core (pass-through), a static force value, or a PWM comparator against a
// shared timebase. Pads sit at SAFE_VAL until boot_done is high.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   boot_done           - pads leave SAFE_VAL only while high
//   core_out            - functional values from the core
//   cfg_we/re/addr      - register port strobes and address
//   cfg_wdata/cfg_rdata - register write data / registered read data
//   pad_o               - flopped values to the pad cells
module pads_out_ctrl
    import pads_out_pkg::*;
#(
    parameter int unsigned       NUM_CH     = 9,
    parameter int unsigned       PWM_W      = 8,
    parameter int unsigned       PRESCALE_W = 16,
    parameter logic [NUM_CH-1:0] SAFE_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_done,
    input  logic [NUM_CH-1:0] core_out,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    output logic [NUM_CH-1:0] pad_o
);

    logic [PRESCALE_W-1:0] r_prescale;
    mode_e                 r_mode [NUM_CH];
    logic [NUM_CH-1:0]     r_force;
    logic [PWM_W-1:0]      r_duty [NUM_CH];

    logic                  w_prescale_we;
    logic [PWM_W-1:0]      w_pwm_cnt;
    logic [NUM_CH-1:0]     w_next;
    logic [DATA_W-1:0]     w_rdata;
    logic                  w_unused_wdata;

    // Not every write-data bit maps to a register field.
    assign w_unused_wdata = ^cfg_wdata;

    assign w_prescale_we = cfg_we && (cfg_addr == ADDR_W'(ADDR_PRESCALE));

    // Timebase restarts whenever PRESCALE is written.
    pads_pwm_timebase #(
        .PRESCALE_W (PRESCALE_W),
        .PWM_W      (PWM_W)
    ) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_prescale_we),
        .i_prescale (r_prescale),
        .o_pwm_cnt  (w_pwm_cnt)
    );

    // Configuration registers; out-of-map addresses are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= '0;
            r_force    <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                r_mode[i] <= MODE_PASS;
                r_duty[i] <= '0;
            end
        end else begin
            if (w_prescale_we) begin
                r_prescale <= cfg_wdata[PRESCALE_W-1:0];
            end
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (cfg_we && (cfg_addr == ADDR_W'(CH_BASE + i))) begin
                    r_mode[i]  <= mode_e'(cfg_wdata[MODE_LSB +: MODE_W]);
                    r_force[i] <= cfg_wdata[FORCE_BIT];
                    r_duty[i]  <= cfg_wdata[DUTY_LSB +: PWM_W];
                end
            end
        end
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        w_rdata = '0;
        if (cfg_addr == ADDR_W'(ADDR_PRESCALE)) begin
            w_rdata[PRESCALE_W-1:0] = r_prescale;
        end
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (cfg_addr == ADDR_W'(CH_BASE + i)) begin
                w_rdata[MODE_LSB +: MODE_W] = r_mode[i];
                w_rdata[FORCE_BIT]          = r_force[i];
                w_rdata[DUTY_LSB +: PWM_W]  = r_duty[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rdata <= '0;
        end else if (cfg_re) begin
            cfg_rdata <= w_rdata;
        end
    end

    // Per-channel source select; reserved mode falls through to the core.
    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        assign w_next[g] = (r_mode[g] == MODE_FORCE) ? r_force[g] :
                           (r_mode[g] == MODE_PWM)   ? (w_pwm_cnt < r_duty[g]) :
                                                       core_out[g];
    end

    always_ff @(posedge clk) begin
        if (rst || !boot_done) begin
            pad_o <= SAFE_VAL;
        end else begin
            pad_o <= w_next;
        end
    end

endmodule
